uart_autobaud_ctrl: RTL and testbench
=====================================

# uart_autobaud_ctrl

Autobaud and configuration controller for the UART baud clock generator. It measures a 0x55 ('U') sync character on the received serial line and derives the 13-bit baud divisor and the 3-bit fractional adjust. It also accepts direct software writes, and commits every new setting to the generator only on an `xmit_pulse` boundary. It sits between the APB register file and the baud clock generator, and owns the generator's `baud_val` and `BAUD_VAL_FRACTION` inputs.

## Interface
Parameters:
- `FRCTN_EN`, default 1: when 1, the fractional value is computed; when 0, `baud_fraction` is forced to 0 and `baud_val` rounds to nearest.
- `RESET_BAUD_VAL`, default 13'd26: `baud_val` value after reset.
- `CNT_W`, default 20: width of the measurement counter.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `rx` in 1: serial receive line, asynchronous to `clk`.
- `autobaud_start` in 1: pulse that arms a measurement.
- `abort` in 1: pulse; returns to IDLE and leaves the outputs unchanged.
- `cfg_wr` in 1: pulse; software write of `cfg_baud_val` and `cfg_fraction`.
- `cfg_baud_val` in 13: software divisor.
- `cfg_fraction` in 3: software fraction.
- `xmit_pulse` in 1: bit-boundary pulse from the baud generator.
- `baud_val` out 13: divisor to the generator.
- `baud_fraction` out 3: fraction to the generator.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a new setting is committed.
- `err` out 1: one-cycle pulse when a measurement fails.
- `err_code` out 2: failure cause, held until the next start. 0 = none, 1 = timeout, 2 = pattern, 3 = range.

## Operation
- `rx` passes through a 2-flop synchronizer; a falling edge is detected on the synchronized signal.
- States and transitions:
  - IDLE: `autobaud_start` -> WAIT_EDGE; `cfg_wr` -> APPLY with the shadow loaded from the cfg inputs.
  - WAIT_EDGE: first falling edge -> MEASURE with counter T = 0 and edge index 1.
  - MEASURE: T increments every cycle. On each falling edge:
    - Edge 2 latches interval I1.
    - Edges 3 to 5 require the current interval Ik to satisfy I1 - I1/4 <= Ik <= I1 + I1/4, otherwise -> ERR (pattern).
    - Edge 5 -> CALC. T then equals 8 bit times.
  - CALC, one cycle:
    - FRCTN_EN = 1: Tr = T + 8; `baud_val` = Tr[CNT_W-1:7] - 1; `baud_fraction` = Tr[6:4].
    - FRCTN_EN = 0: Tr = T + 64; fraction = 0.
    - Tr[CNT_W-1:7] == 0 or > 8192 -> ERR (range). Otherwise the shadow is loaded -> APPLY.
  - APPLY: on `xmit_pulse` == 1, the outputs are loaded from the shadow, `done` pulses, -> IDLE.
  - ERR: `err` pulses, `err_code` is set, -> IDLE. The outputs are unchanged.
- Timeout: T reaching all-ones in WAIT_EDGE or MEASURE -> ERR (timeout). In WAIT_EDGE the counter runs from arm.
- Priority in IDLE: `autobaud_start` wins over a simultaneous `cfg_wr`; the `cfg_wr` is dropped.
- `cfg_wr` outside IDLE is ignored.
- `abort` has the highest priority in every state.
- `abort` in APPLY discards the shadow.

## Timing
- Reset values:
  - `baud_val` = RESET_BAUD_VAL.
  - `baud_fraction` = 0.
  - `busy`, `done`, `err` = 0.
  - `err_code` = 0.
  - State = IDLE.
- Edge-detect latency is 3 clk from `rx` to the internal edge strobe. This latency is equal for all edges, so T is exact to ±1 cycle.
- `busy` rises in the cycle after `autobaud_start` or `cfg_wr` is sampled.
- The outputs change, and `done` pulses, in the clock edge following the cycle in which `xmit_pulse` is sampled high in APPLY.
- An `xmit_pulse` coincident with APPLY entry is not used; the commit waits for the next one.
- Measurement-to-commit latency is 1 (CALC) + 1 + up to 16 baud ticks.
- Reset asserted mid-operation returns the block to its reset values immediately.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum (IDLE, WAIT_EDGE, MEASURE, CALC, APPLY, ERR);
  - the `err_code` constants;
  - the sync pattern edge count, 5.
- Sub-module `uart_rx_edge_det` holds the 2-flop synchronizer and falling-edge strobe; it is reusable by the receiver.
- The FSM, counter, interval check and divisor arithmetic live in the top-level module.

## Test plan
- 50 MHz clk, 0x55 sent at 115200 (434 clk/bit, T = 3472) -> `baud_val` = 26, `baud_fraction` = 1, `done` pulse after `xmit_pulse`.
- FRCTN_EN = 0, same stimulus -> `baud_val` = 26, `baud_fraction` = 0.
- 0x00 sent after arm (single falling edge) -> `err`, `err_code` = 1 after 2^20 cycles; outputs unchanged.
- 0x33 sent (bit widths doubled mid-pattern) -> `err_code` = 2; outputs unchanged.
- `cfg_wr` with 13'd100 / 3'd5 while idle -> outputs update exactly one clk after the next `xmit_pulse`; `cfg_wr` while MEASURE is ignored.
- `abort` during APPLY, and `aresetn` asserted mid-MEASURE -> IDLE; `baud_val` holds its prior value or returns to the reset value of 26.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM states, error codes and sync pattern constants.
package uart_pkg;

  localparam int unsigned BAUD_W     = 13;
  localparam int unsigned FRAC_W     = 3;
  localparam int unsigned EDGE_IDX_W = 3;

  // Falling edges in a 0x55 character: start bit plus four 1->0 data transitions
  localparam int unsigned SYNC_EDGES = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_EDGE,
    ST_MEASURE,
    ST_CALC,
    ST_APPLY,
    ST_ERR
  } ab_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_PATTERN = 2'd2;
  localparam logic [1:0] ERR_RANGE   = 2'd3;

endpackage

// File: rtl/uart_rx_edge_det.sv
// Two-flop synchronizer for the asynchronous rx line plus a registered falling-edge strobe.
module uart_rx_edge_det (
  input  logic clk,
  input  logic aresetn,
  input  logic rx,
  output logic fall_stb
);

  // sync_q[1:0] is the synchronizer, sync_q[2] holds the previous synchronized value
  logic [2:0] sync_q;

  // Synchronize rx and flag a 1->0 transition; the line idles high
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sync_q   <= 3'b111;
      fall_stb <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], rx};
      fall_stb <= sync_q[2] & ~sync_q[1];
    end
  end

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Autobaud / configuration controller: measures a 0x55 sync character, derives the
// baud divisor and fraction, accepts software writes, and commits on xmit_pulse.
module uart_autobaud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FRCTN_EN       = 1,
  parameter logic [12:0] RESET_BAUD_VAL = 13'd26,
  parameter int unsigned CNT_W          = 20
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                rx,
  input  logic                autobaud_start,
  input  logic                abort,
  input  logic                cfg_wr,
  input  logic [BAUD_W-1:0]   cfg_baud_val,
  input  logic [FRAC_W-1:0]   cfg_fraction,
  input  logic                xmit_pulse,
  output logic [BAUD_W-1:0]   baud_val,
  output logic [FRAC_W-1:0]   baud_fraction,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam int unsigned QW = CNT_W - 7;
  localparam int unsigned IW = CNT_W + 1;

  ab_state_t              state;
  logic [CNT_W-1:0]       t_cnt;
  logic [CNT_W-1:0]       t_prev;
  logic [CNT_W-1:0]       i1;
  logic [EDGE_IDX_W-1:0]  edge_idx;
  logic [BAUD_W-1:0]      shadow_val;
  logic [FRAC_W-1:0]      shadow_frac;
  logic [1:0]             err_pend;
  logic                   fall_stb;

  logic [CNT_W-1:0]       t_nxt_c;
  logic [CNT_W-1:0]       ik_c;
  logic [IW-1:0]          lo_c;
  logic [IW-1:0]          hi_c;
  logic                   ik_ok_c;
  logic                   t_full_c;
  logic [CNT_W-1:0]       tr_c;
  logic [QW-1:0]          q_c;
  logic                   range_bad_c;
  logic [BAUD_W-1:0]      div_c;
  logic [FRAC_W-1:0]      frac_c;

  uart_rx_edge_det u_edge_det (
    .clk      (clk),
    .aresetn  (aresetn),
    .rx       (rx),
    .fall_stb (fall_stb)
  );

  // Interval window check: current interval must lie within I1 +/- I1/4
  always_comb begin
    t_nxt_c  = t_cnt + CNT_W'(1);
    ik_c     = t_nxt_c - t_prev;
    lo_c     = IW'(i1) - IW'(i1 >> 2);
    hi_c     = IW'(i1) + IW'(i1 >> 2);
    ik_ok_c  = (IW'(ik_c) >= lo_c) && (IW'(ik_c) <= hi_c);
    t_full_c = &t_cnt;
  end

  // Divisor arithmetic: T spans 8 bit times, so T/128 is the 16x-oversampled divisor
  always_comb begin
    tr_c        = t_cnt + CNT_W'((FRCTN_EN != 0) ? 8 : 64);
    q_c         = QW'(tr_c >> 7);
    range_bad_c = (q_c == '0) || (32'(q_c) > 32'd8192);
    div_c       = BAUD_W'(32'(q_c) - 32'd1);
    frac_c      = (FRCTN_EN != 0) ? FRAC_W'(tr_c >> 4) : '0;
  end

  // Autobaud FSM with measurement counter and registered outputs
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      t_cnt         <= '0;
      t_prev        <= '0;
      i1            <= '0;
      edge_idx      <= '0;
      shadow_val    <= '0;
      shadow_frac   <= '0;
      err_pend      <= ERR_NONE;
      baud_val      <= RESET_BAUD_VAL;
      baud_fraction <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (autobaud_start) begin
              state    <= ST_WAIT_EDGE;
              busy     <= 1'b1;
              t_cnt    <= '0;
              err_code <= ERR_NONE;
            end else if (cfg_wr) begin
              shadow_val  <= cfg_baud_val;
              shadow_frac <= cfg_fraction;
              state       <= ST_APPLY;
              busy        <= 1'b1;
            end
          end
          ST_WAIT_EDGE: begin
            if (t_full_c) begin
              err_pend <= ERR_TIMEOUT;
              state    <= ST_ERR;
            end else if (fall_stb) begin
              state    <= ST_MEASURE;
              t_cnt    <= '0;
              t_prev   <= '0;
              edge_idx <= EDGE_IDX_W'(1);
            end else begin
              t_cnt <= t_nxt_c;
            end
          end
          ST_MEASURE: begin
            t_cnt <= t_nxt_c;
            if (t_full_c) begin
              err_pend <= ERR_TIMEOUT;
              state    <= ST_ERR;
            end else if (fall_stb) begin
              edge_idx <= edge_idx + EDGE_IDX_W'(1);
              t_prev   <= t_nxt_c;
              if (edge_idx == EDGE_IDX_W'(1)) begin
                i1 <= t_nxt_c;
              end else if (!ik_ok_c) begin
                err_pend <= ERR_PATTERN;
                state    <= ST_ERR;
              end else if (edge_idx == EDGE_IDX_W'(SYNC_EDGES - 1)) begin
                state <= ST_CALC;
              end
            end
          end
          ST_CALC: begin
            if (range_bad_c) begin
              err_pend <= ERR_RANGE;
              state    <= ST_ERR;
            end else begin
              shadow_val  <= div_c;
              shadow_frac <= frac_c;
              state       <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            if (xmit_pulse) begin
              baud_val      <= shadow_val;
              baud_fraction <= shadow_frac;
              done          <= 1'b1;
              state         <= ST_IDLE;
              busy          <= 1'b0;
            end
          end
          ST_ERR: begin
            err      <= 1'b1;
            err_code <= err_pend;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Self-checking bench for uart_autobaud_ctrl: table of transactions plus corner sequences,
// with a scoreboard of expected commit/error events.
module tb_uart_autobaud_ctrl;

  logic        clk;
  logic        aresetn;
  logic        rx;
  logic        xmit_gen;
  logic        xmit_man;
  logic        xmit_pulse;
  logic        xmit_auto;
  logic [12:0] cfg_val;
  logic [2:0]  cfg_frac;

  logic        a_start, a_abort, a_cfg_wr;
  logic [12:0] a_baud_val;
  logic [2:0]  a_frac;
  logic        a_busy, a_done, a_err;
  logic [1:0]  a_err_code;

  logic        b_start, b_abort, b_cfg_wr;
  logic [12:0] b_baud_val;
  logic [2:0]  b_frac;
  logic        b_busy, b_done, b_err;
  logic [1:0]  b_err_code;

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic [12:0] val;
    logic [2:0]  frac;
  } exp_t;

  typedef struct {
    int          kind;      // 0 = software write, 1 = serial sync character
    logic [12:0] cfg_val;
    logic [2:0]  cfg_frac;
    logic [7:0]  data;
    int          bit_clks;
    logic        is_err;
    logic [1:0]  code;
    logic [12:0] val;
    logic [2:0]  frac;
  } vec_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  vec_t vecs[8];

  int n_checks = 0;
  int n_pass   = 0;
  int ev_a     = 0;
  int ev_b     = 0;
  int xcnt     = 0;

  assign xmit_pulse = xmit_gen | xmit_man;

  uart_autobaud_ctrl dut_a (
    .clk            (clk),
    .aresetn        (aresetn),
    .rx             (rx),
    .autobaud_start (a_start),
    .abort          (a_abort),
    .cfg_wr         (a_cfg_wr),
    .cfg_baud_val   (cfg_val),
    .cfg_fraction   (cfg_frac),
    .xmit_pulse     (xmit_pulse),
    .baud_val       (a_baud_val),
    .baud_fraction  (a_frac),
    .busy           (a_busy),
    .done           (a_done),
    .err            (a_err),
    .err_code       (a_err_code)
  );

  uart_autobaud_ctrl #(
    .FRCTN_EN       (0),
    .RESET_BAUD_VAL (13'd26),
    .CNT_W          (13)
  ) dut_b (
    .clk            (clk),
    .aresetn        (aresetn),
    .rx             (rx),
    .autobaud_start (b_start),
    .abort          (b_abort),
    .cfg_wr         (b_cfg_wr),
    .cfg_baud_val   (cfg_val),
    .cfg_fraction   (cfg_frac),
    .xmit_pulse     (xmit_pulse),
    .baud_val       (b_baud_val),
    .baud_fraction  (b_frac),
    .busy           (b_busy),
    .done           (b_done),
    .err            (b_err),
    .err_code       (b_err_code)
  );

  // 50 MHz clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Free-running baud tick every 16 clocks when enabled
  initial begin
    xmit_gen = 1'b0;
    forever begin
      @(negedge clk);
      xcnt = xcnt + 1;
      xmit_gen = xmit_auto && ((xcnt % 16) == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
  endtask

  // Scoreboard: every done/err pulse pops and compares one expected event
  always @(negedge clk) begin
    if (aresetn) begin
      if (a_done || a_err) begin
        ev_a = ev_a + 1;
        check("a_event_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          ea = qa.pop_front();
          check($sformatf("a_event%0d", ev_a),
                32'({a_err, (a_err ? a_err_code : 2'b00), a_baud_val, a_frac}),
                32'({ea.is_err, ea.code, ea.val, ea.frac}));
        end
      end
      if (b_done || b_err) begin
        ev_b = ev_b + 1;
        check("b_event_expected", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) begin
          eb = qb.pop_front();
          check($sformatf("b_event%0d", ev_b),
                32'({b_err, (b_err ? b_err_code : 2'b00), b_baud_val, b_frac}),
                32'({eb.is_err, eb.code, eb.val, eb.frac}));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input int bc);
    rx = 1'b0;
    repeat (bc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (bc) @(negedge clk);
    end
    rx = 1'b1;
    repeat (bc) @(negedge clk);
  endtask

  task automatic pulse_start(input bit sel_b);
    @(negedge clk);
    if (sel_b) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic cfg_write_a(input logic [12:0] v, input logic [2:0] f);
    @(negedge clk);
    a_cfg_wr = 1'b1;
    cfg_val  = v;
    cfg_frac = f;
    @(negedge clk);
    a_cfg_wr = 1'b0;
  endtask

  task automatic wait_ev(input bit sel_b, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (((sel_b ? ev_b : ev_a) < target) && (n < budget)) begin
      @(negedge clk);
      n = n + 1;
    end
    check(name, 32'((sel_b ? ev_b : ev_a) >= target), 32'd1);
  endtask

  initial begin
    int base;
    exp_t e;

    vecs[0] = '{0, 13'd100,  3'd5, 8'h00, 0,   1'b0, 2'd0, 13'd100,  3'd5};
    vecs[1] = '{1, 13'd0,    3'd0, 8'h55, 434, 1'b0, 2'd0, 13'd26,   3'd1};
    vecs[2] = '{1, 13'd0,    3'd0, 8'h55, 217, 1'b0, 2'd0, 13'd12,   3'd5};
    vecs[3] = '{1, 13'd0,    3'd0, 8'h33, 434, 1'b1, 2'd2, 13'd12,   3'd5};
    vecs[4] = '{1, 13'd0,    3'd0, 8'h55, 100, 1'b0, 2'd0, 13'd5,    3'd2};
    vecs[5] = '{1, 13'd0,    3'd0, 8'h55, 16,  1'b0, 2'd0, 13'd0,    3'd0};
    vecs[6] = '{1, 13'd0,    3'd0, 8'h55, 8,   1'b1, 2'd3, 13'd0,    3'd0};
    vecs[7] = '{0, 13'd8191, 3'd7, 8'h00, 0,   1'b0, 2'd0, 13'd8191, 3'd7};

    aresetn   = 1'b0;
    rx        = 1'b1;
    xmit_auto = 1'b0;
    xmit_man  = 1'b0;
    cfg_val   = '0;
    cfg_frac  = '0;
    a_start = 1'b0; a_abort = 1'b0; a_cfg_wr = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_cfg_wr = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_a_baud_val", 32'(a_baud_val), 32'd26);
    check("rst_a_fraction", 32'(a_frac), 32'd0);
    check("rst_a_busy", 32'(a_busy), 32'd0);
    check("rst_a_done", 32'(a_done), 32'd0);
    check("rst_a_err", 32'(a_err), 32'd0);
    check("rst_a_err_code", 32'(a_err_code), 32'd0);
    check("rst_b_baud_val", 32'(b_baud_val), 32'd26);
    check("rst_b_fraction", 32'(b_frac), 32'd0);
    aresetn = 1'b1;
    repeat (3) @(negedge clk);

    // busy rises the cycle after start is sampled; abort returns to idle
    a_start = 1'b1;
    check("busy_before_start", 32'(a_busy), 32'd0);
    @(negedge clk);
    a_start = 1'b0;
    check("busy_after_start", 32'(a_busy), 32'd1);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("busy_after_abort", 32'(a_busy), 32'd0);
    check("abort_keeps_baud_val", 32'(a_baud_val), 32'd26);

    // Table of transactions on the fractional instance
    xmit_auto = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e.is_err = vecs[i].is_err;
      e.code   = vecs[i].code;
      e.val    = vecs[i].val;
      e.frac   = vecs[i].frac;
      base = ev_a;
      qa.push_back(e);
      if (vecs[i].kind == 0) begin
        cfg_write_a(vecs[i].cfg_val, vecs[i].cfg_frac);
      end else begin
        pulse_start(1'b0);
        repeat (4) @(negedge clk);
        send_byte(vecs[i].data, vecs[i].bit_clks);
        repeat (20) @(negedge clk);
      end
      wait_ev(1'b0, base + 1, 2000, $sformatf("vec%0d_event_seen", i));
      if (vecs[i].is_err) check($sformatf("vec%0d_err_code_held", i), 32'(a_err_code), 32'(vecs[i].code));
    end

    // cfg_wr during MEASURE is ignored; measurement completes normally
    e = '{1'b0, 2'd0, 13'd12, 3'd5};
    base = ev_a;
    qa.push_back(e);
    pulse_start(1'b0);
    repeat (4) @(negedge clk);
    fork
      send_byte(8'h55, 217);
      begin
        repeat (1000) @(negedge clk);
        a_cfg_wr = 1'b1;
        cfg_val  = 13'd77;
        cfg_frac = 3'd3;
        @(negedge clk);
        a_cfg_wr = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    wait_ev(1'b0, base + 1, 2000, "measure_cfg_ignored_event");
    check("measure_cfg_ignored_idle", 32'(a_busy), 32'd0);
    check("measure_cfg_ignored_val", 32'(a_baud_val), 32'd12);

    // Software write commits exactly at the clock after xmit_pulse; entry-coincident tick unused
    xmit_auto = 1'b0;
    repeat (3) @(negedge clk);
    e = '{1'b0, 2'd0, 13'd100, 3'd5};
    base = ev_a;
    qa.push_back(e);
    a_cfg_wr = 1'b1;
    cfg_val  = 13'd100;
    cfg_frac = 3'd5;
    xmit_man = 1'b1;
    @(negedge clk);
    a_cfg_wr = 1'b0;
    xmit_man = 1'b0;
    repeat (4) @(negedge clk);
    check("apply_wait_val", 32'(a_baud_val), 32'd12);
    check("apply_wait_busy", 32'(a_busy), 32'd1);
    xmit_man = 1'b1;
    check("apply_pre_tick_done", 32'(a_done), 32'd0);
    @(negedge clk);
    xmit_man = 1'b0;
    check("apply_commit_val", 32'(a_baud_val), 32'd100);
    check("apply_commit_frac", 32'(a_frac), 32'd5);
    check("apply_commit_done", 32'(a_done), 32'd1);
    @(negedge clk);
    check("apply_done_one_cycle", 32'(a_done), 32'd0);
    check("apply_event_count", 32'(ev_a), 32'(base + 1));

    // abort in APPLY discards the shadow
    base = ev_a;
    cfg_write_a(13'd55, 3'd3);
    repeat (2) @(negedge clk);
    check("abort_apply_busy", 32'(a_busy), 32'd1);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    check("abort_apply_idle", 32'(a_busy), 32'd0);
    xmit_man = 1'b1;
    @(negedge clk);
    xmit_man = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_apply_val", 32'(a_baud_val), 32'd100);
    check("abort_apply_no_event", 32'(ev_a), 32'(base));

    // Reset asserted mid-MEASURE returns to reset values
    xmit_auto = 1'b1;
    pulse_start(1'b0);
    repeat (4) @(negedge clk);
    fork
      send_byte(8'h55, 217);
      begin
        repeat (900) @(negedge clk);
        aresetn = 1'b0;
        #1;
        check("midrst_busy", 32'(a_busy), 32'd0);
        check("midrst_val", 32'(a_baud_val), 32'd26);
        check("midrst_frac", 32'(a_frac), 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
      end
    join
    repeat (20) @(negedge clk);
    check("midrst_stays_idle", 32'(a_busy), 32'd0);
    check("midrst_val_after", 32'(a_baud_val), 32'd26);

    // Integer-only instance: rounding to nearest, fraction forced to 0
    e = '{1'b0, 2'd0, 13'd13, 3'd0};
    base = ev_b;
    qb.push_back(e);
    pulse_start(1'b1);
    repeat (4) @(negedge clk);
    send_byte(8'h55, 217);
    repeat (20) @(negedge clk);
    wait_ev(1'b1, base + 1, 2000, "nofrac_217_event");

    e = '{1'b0, 2'd0, 13'd26, 3'd0};
    base = ev_b;
    qb.push_back(e);
    pulse_start(1'b1);
    repeat (4) @(negedge clk);
    send_byte(8'h55, 434);
    repeat (20) @(negedge clk);
    wait_ev(1'b1, base + 1, 2000, "nofrac_434_event");
    check("nofrac_434_frac", 32'(b_frac), 32'd0);

    // Timeout in MEASURE: a single falling edge
    e = '{1'b1, 2'd1, 13'd26, 3'd0};
    base = ev_b;
    qb.push_back(e);
    pulse_start(1'b1);
    repeat (4) @(negedge clk);
    send_byte(8'h00, 434);
    wait_ev(1'b1, base + 1, 10000, "timeout_measure_event");
    repeat (5) @(negedge clk);
    check("timeout_code_held", 32'(b_err_code), 32'd1);
    check("timeout_idle", 32'(b_busy), 32'd0);

    // Timeout in WAIT_EDGE: no activity after arm; start clears the old code
    e = '{1'b1, 2'd1, 13'd26, 3'd0};
    base = ev_b;
    qb.push_back(e);
    pulse_start(1'b1);
    repeat (5) @(negedge clk);
    check("start_clears_code", 32'(b_err_code), 32'd0);
    check("wait_edge_busy", 32'(b_busy), 32'd1);
    wait_ev(1'b1, base + 1, 9000, "timeout_wait_edge_event");

    repeat (10) @(negedge clk);
    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
